// File: rtl/keychain_pkg.sv
// Shared definitions for the keychain RSA controller.
//   state_t    : controller FSM states (SEND/TXW phases live in byte_serializer)
//   HDR_MARKER : required upper nibble of a frame header byte
//   ERR_BYTE   : single byte returned for a rejected request
package keychain_pkg;

  typedef enum logic [2:0] {IDLE, RECV, CHECK, START, WAIT, ERR, SEND, TXW} state_t;

  localparam logic [3:0] HDR_MARKER = 4'hA;
  localparam logic [7:0] ERR_BYTE   = 8'hEE;

endpackage

// File: rtl/keychain_rsa_ctrl_byte_serializer.sv
// byte_serializer: shifts a WIDTH-bit word out to a UART transmitter, MSB byte
// first, one tx_trigger_out strobe per byte.
//   clk_in, rst_n_in : clock, asynchronous active-low reset
//   load_in          : start a transfer (accepted only when idle)
//   data_in          : word to send, first byte in [WIDTH-1:WIDTH-8]
//   count_in         : number of bytes to send (1..WIDTH/8)
//   tx_busy_in       : transmitter busy
//   tx_byte_out      : byte presented to the transmitter
//   tx_trigger_out   : one-cycle transmit strobe
//   done_out         : one-cycle pulse in the cycle the last byte completes
module byte_serializer
  import keychain_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int BYTES = WIDTH / 8,
  localparam int CW    = $clog2(BYTES + 1)
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             load_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic [CW-1:0]    count_in,
  input  logic             tx_busy_in,
  output logic [7:0]       tx_byte_out,
  output logic             tx_trigger_out,
  output logic             done_out
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             first_q, first_d;
  logic [7:0]       byte_q, byte_d;
  logic             trig_q, trig_d;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      first_q <= 1'b0;
      byte_q  <= '0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      byte_q  <= byte_d;
      trig_q  <= trig_d;
    end
  end

  // The transmitter only raises busy after seeing the trigger, so the first
  // TXW cycle must not read tx_busy_in.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_in) state_d = SEND;
      SEND:    if (!tx_busy_in) state_d = TXW;
      TXW:     if (!first_q && !tx_busy_in) state_d = (cnt_q == CW'(1)) ? IDLE : SEND;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    first_d  = 1'b0;
    byte_d   = byte_q;
    trig_d   = 1'b0;
    done_out = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_in) begin
          shift_d = data_in;
          cnt_d   = count_in;
        end
      end
      SEND: begin
        if (!tx_busy_in) begin
          byte_d  = shift_q[WIDTH-1 -: 8];
          trig_d  = 1'b1;
          first_d = 1'b1;
        end
      end
      TXW: begin
        if (!first_q && !tx_busy_in) begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) done_out = 1'b1;
          else                 shift_d  = shift_q << 8;
        end
      end
      default: ;
    endcase
  end

  assign tx_byte_out    = byte_q;
  assign tx_trigger_out = trig_q;

endmodule

// File: rtl/keychain_rsa_ctrl.sv
// keychain_rsa_ctrl: UART-framed modular-exponentiation controller.
// Receives {header, BYTES value bytes MSB first}, picks a key slot from the
// header, validates the operand, starts the external engine and returns the
// result (or ERR_BYTE) over UART through byte_serializer.
//   clk_in, rst_n_in         : clock, asynchronous active-low reset
//   rx_valid_in, rx_byte_in  : received byte strobe / data
//   tx_byte_out, tx_trigger_out, tx_busy_in : transmitter handshake
//   key_we_in, key_sel_in, key_exp_in, key_mod_in : key table write port
//   em_*                     : exponent_modulus engine handshake
//   busy_out                 : controller not idle
//   err_out, overrun_out     : error-byte queued / rx byte dropped pulses
module keychain_rsa_ctrl
  import keychain_pkg::*;
#(
  parameter  int WIDTH          = 16,
  parameter  int NUM_KEYS       = 4,
  parameter  int TIMEOUT_CYCLES = 1_000_000,
  localparam int BYTES          = WIDTH / 8,
  localparam int KW             = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             rx_valid_in,
  input  logic [7:0]       rx_byte_in,
  output logic [7:0]       tx_byte_out,
  output logic             tx_trigger_out,
  input  logic             tx_busy_in,
  input  logic             key_we_in,
  input  logic [KW-1:0]    key_sel_in,
  input  logic [WIDTH-1:0] key_exp_in,
  input  logic [WIDTH-1:0] key_mod_in,
  output logic             em_ready_out,
  output logic [WIDTH-1:0] em_value_out,
  output logic [WIDTH-1:0] em_exponent_out,
  output logic [WIDTH-1:0] em_modulus_out,
  input  logic [WIDTH-1:0] em_result_in,
  input  logic             em_busy_in,
  input  logic             em_valid_in,
  output logic             busy_out,
  output logic             err_out,
  output logic             overrun_out
);

  localparam int CW = $clog2(BYTES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t           state_q, state_d;
  logic [3:0]       slot_q, slot_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [CW-1:0]    bcnt_q, bcnt_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [WIDTH-1:0] em_value_q, em_value_d;
  logic [WIDTH-1:0] em_exp_q, em_exp_d;
  logic [WIDTH-1:0] em_mod_q, em_mod_d;
  logic             overrun_q, overrun_d;

  // Engine results arrive as a strobe; busy is informational only.
  logic unused_em_busy;
  assign unused_em_busy = em_busy_in;

  // Key table: one register pair per slot. Out-of-range selects match no slot.
  logic [WIDTH-1:0] key_exp_all [NUM_KEYS];
  logic [WIDTH-1:0] key_mod_all [NUM_KEYS];

  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      logic [WIDTH-1:0] exp_q;
      logic [WIDTH-1:0] mod_q;
      always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
          exp_q <= '0;
          mod_q <= '0;
        end else if (key_we_in && key_sel_in == KW'(gi)) begin
          exp_q <= key_exp_in;
          mod_q <= key_mod_in;
        end
      end
      assign key_exp_all[gi] = exp_q;
      assign key_mod_all[gi] = mod_q;
    end
  endgenerate

  logic [WIDTH-1:0] sel_exp, sel_mod;
  logic             slot_bad, operand_bad, hdr_ok, last_byte;

  assign slot_bad    = ({1'b0, slot_q} >= 5'(NUM_KEYS));
  assign sel_exp     = key_exp_all[slot_q[KW-1:0]];
  assign sel_mod     = key_mod_all[slot_q[KW-1:0]];
  assign operand_bad = slot_bad || (sel_mod == '0) || (value_q >= sel_mod);
  assign hdr_ok      = rx_valid_in && (rx_byte_in[7:4] == HDR_MARKER);
  assign last_byte   = rx_valid_in && (bcnt_q == CW'(BYTES - 1));

  logic             ser_load, ser_done;
  logic [WIDTH-1:0] ser_data;
  logic [CW-1:0]    ser_count;

  // State register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= IDLE;
      slot_q     <= '0;
      value_q    <= '0;
      bcnt_q     <= '0;
      tmo_q      <= '0;
      em_value_q <= '0;
      em_exp_q   <= '0;
      em_mod_q   <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      value_q    <= value_d;
      bcnt_q     <= bcnt_d;
      tmo_q      <= tmo_d;
      em_value_q <= em_value_d;
      em_exp_q   <= em_exp_d;
      em_mod_q   <= em_mod_d;
      overrun_q  <= overrun_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (hdr_ok) state_d = RECV;
      RECV: begin
        if (last_byte)                                        state_d = CHECK;
        else if (!rx_valid_in && tmo_q == TW'(TIMEOUT_CYCLES)) state_d = IDLE;
      end
      CHECK: state_d = operand_bad ? ERR : START;
      START: state_d = WAIT;
      WAIT:  if (em_valid_in) state_d = SEND;
      ERR:   state_d = SEND;
      SEND:  if (ser_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and outputs
  always_comb begin
    slot_d     = slot_q;
    value_d    = value_q;
    bcnt_d     = bcnt_q;
    tmo_d      = tmo_q;
    em_value_d = em_value_q;
    em_exp_d   = em_exp_q;
    em_mod_d   = em_mod_q;
    case (state_q)
      IDLE: begin
        if (hdr_ok) begin
          slot_d = rx_byte_in[3:0];
          bcnt_d = '0;
          tmo_d  = '0;
        end
      end
      RECV: begin
        if (rx_valid_in) begin
          value_d = {value_q[WIDTH-9:0], rx_byte_in};
          bcnt_d  = bcnt_q + CW'(1);
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      CHECK: begin
        // Operands hold from here until the next accepted frame's CHECK.
        if (!operand_bad) begin
          em_value_d = value_q;
          em_exp_d   = sel_exp;
          em_mod_d   = sel_mod;
        end
      end
      default: ;
    endcase

    overrun_d = rx_valid_in && (state_q != IDLE) && (state_q != RECV);
    ser_load  = (state_q == ERR) || (state_q == WAIT && em_valid_in);
    ser_data  = (state_q == ERR) ? {ERR_BYTE, {(WIDTH-8){1'b0}}} : em_result_in;
    ser_count = (state_q == ERR) ? CW'(1) : CW'(BYTES);
  end

  assign em_ready_out    = (state_q == START);
  assign err_out         = (state_q == ERR);
  assign busy_out        = (state_q != IDLE);
  assign overrun_out     = overrun_q;
  assign em_value_out    = em_value_q;
  assign em_exponent_out = em_exp_q;
  assign em_modulus_out  = em_mod_q;

  byte_serializer #(.WIDTH(WIDTH)) u_ser (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .load_in        (ser_load),
    .data_in        (ser_data),
    .count_in       (ser_count),
    .tx_busy_in     (tx_busy_in),
    .tx_byte_out    (tx_byte_out),
    .tx_trigger_out (tx_trigger_out),
    .done_out       (ser_done)
  );

endmodule

// File: tb/tb_keychain_rsa_ctrl.sv
module tb_keychain_rsa_ctrl;
  localparam int WIDTH    = 16;
  localparam int NUM_KEYS = 4;
  localparam int TMO      = 50;
  localparam int KW       = 2;

  logic             clk_in = 1'b0;
  logic             rst_n_in;
  logic             rx_valid_in;
  logic [7:0]       rx_byte_in;
  logic [7:0]       tx_byte_out;
  logic             tx_trigger_out;
  logic             tx_busy_in;
  logic             key_we_in;
  logic [KW-1:0]    key_sel_in;
  logic [WIDTH-1:0] key_exp_in, key_mod_in;
  logic             em_ready_out;
  logic [WIDTH-1:0] em_value_out, em_exponent_out, em_modulus_out;
  logic [WIDTH-1:0] em_result_in;
  logic             em_busy_in, em_valid_in;
  logic             busy_out, err_out, overrun_out;

  keychain_rsa_ctrl #(.WIDTH(WIDTH), .NUM_KEYS(NUM_KEYS), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .rx_valid_in(rx_valid_in), .rx_byte_in(rx_byte_in),
    .tx_byte_out(tx_byte_out), .tx_trigger_out(tx_trigger_out), .tx_busy_in(tx_busy_in),
    .key_we_in(key_we_in), .key_sel_in(key_sel_in), .key_exp_in(key_exp_in), .key_mod_in(key_mod_in),
    .em_ready_out(em_ready_out), .em_value_out(em_value_out), .em_exponent_out(em_exponent_out),
    .em_modulus_out(em_modulus_out), .em_result_in(em_result_in), .em_busy_in(em_busy_in),
    .em_valid_in(em_valid_in), .busy_out(busy_out), .err_out(err_out), .overrun_out(overrun_out)
  );

  always #5 clk_in = ~clk_in;

  int vectors = 0, miscompares = 0;
  int exp_err = 0, got_err = 0, exp_ovr = 0, got_ovr = 0;
  logic [7:0]  exp_tx_q[$];
  logic [47:0] exp_em_q[$];
  logic [15:0] model_exp [NUM_KEYS];
  logic [15:0] model_mod [NUM_KEYS];

  function automatic longint unsigned modpow(longint unsigned b, longint unsigned e, longint unsigned m);
    longint unsigned r = 1 % m;
    b = b % m;
    while (e > 0) begin
      if (e[0]) r = (r * b) % m;
      b = (b * b) % m;
      e = e >> 1;
    end
    return r;
  endfunction

  // Reference model: what a frame must produce, from the key table alone.
  task automatic push_expect(input logic [7:0] hdr, input logic [15:0] val);
    int slot;
    longint unsigned r;
    if (hdr[7:4] != 4'hA) return;
    slot = int'(hdr[3:0]);
    if (slot >= NUM_KEYS || model_mod[slot] == 0 || val >= model_mod[slot]) begin
      exp_tx_q.push_back(8'hEE);
      exp_err++;
    end else begin
      r = modpow(val, model_exp[slot], model_mod[slot]);
      exp_tx_q.push_back(r[15:8]);
      exp_tx_q.push_back(r[7:0]);
      exp_em_q.push_back({val, model_exp[slot], model_mod[slot]});
    end
  endtask

  // Transmit monitor: one line per byte sent.
  initial forever begin
    @(negedge clk_in);
    if (rst_n_in && tx_trigger_out) begin
      vectors++;
      if (exp_tx_q.size() == 0) begin
        miscompares++;
        $display("FAIL tx_byte: unexpected byte %02h, none expected", tx_byte_out);
      end else begin
        logic [7:0] e;
        e = exp_tx_q.pop_front();
        if (tx_byte_out !== e) begin
          miscompares++;
          $display("FAIL tx_byte: got %02h expected %02h", tx_byte_out, e);
        end else $display("tx byte %02h", tx_byte_out);
      end
    end
  end

  // Engine-start monitor.
  initial forever begin
    @(negedge clk_in);
    if (rst_n_in && em_ready_out) begin
      vectors++;
      if (exp_em_q.size() == 0) begin
        miscompares++;
        $display("FAIL em_start: unexpected start value=%0d", em_value_out);
      end else begin
        logic [47:0] e;
        e = exp_em_q.pop_front();
        if ({em_value_out, em_exponent_out, em_modulus_out} !== e) begin
          miscompares++;
          $display("FAIL em_start: got v=%0d e=%0d m=%0d expected v=%0d e=%0d m=%0d",
                   em_value_out, em_exponent_out, em_modulus_out, e[47:32], e[31:16], e[15:0]);
        end else $display("em start v=%0d e=%0d m=%0d", em_value_out, em_exponent_out, em_modulus_out);
      end
    end
  end

  initial forever begin
    @(negedge clk_in);
    if (err_out) got_err++;
    if (overrun_out) got_ovr++;
  end

  // Behavioural engine: random latency, then one result strobe.
  initial begin
    em_valid_in = 1'b0; em_busy_in = 1'b0; em_result_in = '0;
    forever begin
      @(negedge clk_in);
      if (em_ready_out) begin
        longint unsigned v, e, m;
        v = em_value_out; e = em_exponent_out; m = em_modulus_out;
        em_busy_in = 1'b1;
        repeat ($urandom_range(1, 8)) @(negedge clk_in);
        em_result_in = WIDTH'(modpow(v, e, m));
        em_valid_in  = 1'b1;
        @(negedge clk_in);
        em_valid_in = 1'b0;
        em_busy_in  = 1'b0;
      end
    end
  end

  // Behavioural UART transmitter: random busy time after each trigger.
  initial begin
    tx_busy_in = 1'b0;
    forever begin
      @(negedge clk_in);
      if (tx_trigger_out) begin
        int n;
        n = $urandom_range(0, 6);
        if (n > 0) begin
          tx_busy_in = 1'b1;
          repeat (n) @(negedge clk_in);
          tx_busy_in = 1'b0;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    rx_valid_in = 1'b1; rx_byte_in = b;
    @(negedge clk_in);
    rx_valid_in = 1'b0;
  endtask

  task automatic write_key(input int sel, input logic [15:0] e, input logic [15:0] m);
    key_we_in = 1'b1; key_sel_in = KW'(sel); key_exp_in = e; key_mod_in = m;
    @(negedge clk_in);
    key_we_in = 1'b0;
    if (sel < NUM_KEYS) begin model_exp[sel] = e; model_mod[sel] = m; end
  endtask

  task automatic check_zero(input string name);
    logic [60:0] v;
    v = {tx_byte_out, tx_trigger_out, em_ready_out, em_value_out, em_exponent_out,
         em_modulus_out, busy_out, err_out, overrun_out};
    vectors++;
    if (v !== 61'd0) begin
      miscompares++;
      $display("FAIL %s: outputs %h expected all zero", name, v);
    end else $display("%s: all outputs zero", name);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    repeat (2) @(negedge clk_in);
    while (busy_out && n < 2000) begin @(negedge clk_in); n++; end
    repeat (2) @(negedge clk_in);
    vectors++;
    if (busy_out || exp_tx_q.size() != 0 || exp_em_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s: busy=%0b pending tx=%0d pending em=%0d, required 0/0/0",
               name, busy_out, exp_tx_q.size(), exp_em_q.size());
    end else $display("%s: frame complete", name);
  endtask

  task automatic run_frame(input logic [7:0] hdr, input logic [15:0] val, input int max_gap);
    push_expect(hdr, val);
    send_byte(hdr);
    if (hdr[7:4] == 4'hA)
      for (int i = 1; i >= 0; i--) begin
        repeat ($urandom_range(0, max_gap)) @(negedge clk_in);
        send_byte(val[i*8 +: 8]);
      end
    wait_idle($sformatf("frame_%02h_%04h", hdr, val));
  endtask

  initial begin
    rst_n_in = 1'b0; rx_valid_in = 1'b0; rx_byte_in = '0; key_we_in = 1'b0;
    key_sel_in = '0; key_exp_in = '0; key_mod_in = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin model_exp[i] = '0; model_mod[i] = '0; end
    repeat (3) @(negedge clk_in);
    check_zero("reset_state");
    rst_n_in = 1'b1;
    repeat (2) @(negedge clk_in);

    write_key(0, 16'd10, 16'd1073);
    run_frame(8'hA0, 16'h0002, 0);            // 1024 -> 04 00
    write_key(1, 16'd3, 16'd1073);
    run_frame(8'hA1, 16'h0005, 3);            // 125 -> 00 7D
    run_frame(8'hA0, 16'h0431, 2);            // value == mod -> EE
    run_frame(8'hA3, 16'h0001, 1);            // unwritten slot -> EE
    run_frame(8'hA7, 16'h0001, 1);            // slot out of range -> EE
    run_frame(8'hB0, 16'h0000, 0);            // bad marker ignored

    // Inter-byte timeout: abandon frame silently, then recover.
    send_byte(8'hA0);
    send_byte(8'h00);
    repeat (TMO + 5) @(negedge clk_in);
    vectors++;
    if (busy_out !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout: busy=%0b required 0", busy_out);
    end else $display("timeout: returned to idle");
    run_frame(8'hA0, 16'h0002, 0);

    // Key write coincident with CHECK must not affect this frame.
    push_expect(8'hA1, 16'h0005);
    send_byte(8'hA1); send_byte(8'h00); send_byte(8'h05);
    write_key(1, 16'd7, 16'd999);
    wait_idle("write_during_check");
    run_frame(8'hA1, 16'h0005, 0);            // uses new key

    // Byte arriving while the engine runs is dropped.
    push_expect(8'hA0, 16'h0002);
    send_byte(8'hA0); send_byte(8'h00); send_byte(8'h02);
    repeat (3) @(negedge clk_in);
    send_byte(8'h55);
    exp_ovr++;
    wait_idle("overrun");

    // Randomised traffic.
    for (int it = 0; it < 40; it++) begin
      logic [7:0]  hdr;
      logic [15:0] val;
      int slot;
      if ($urandom_range(0, 3) == 0)
        write_key($urandom_range(0, NUM_KEYS-1), 16'($urandom_range(0, 20)),
                  ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom_range(1, 65535)));
      slot = $urandom_range(0, 5);
      hdr  = ($urandom_range(0, 9) == 0) ? {4'h3, 4'(slot)} : {4'hA, 4'(slot)};
      if (slot < NUM_KEYS && model_mod[slot] != 0 && $urandom_range(0, 1) == 1)
        val = 16'($urandom_range(0, int'(model_mod[slot]) - 1));
      else
        val = 16'($urandom);
      run_frame(hdr, val, 10);
    end

    // Reset while sending: outputs clear at once, key table is wiped.
    write_key(0, 16'd10, 16'd1073);
    push_expect(8'hA0, 16'h0002);
    send_byte(8'hA0); send_byte(8'h00); send_byte(8'h02);
    begin
      int n = 0;
      while (!tx_trigger_out && n < 200) begin @(negedge clk_in); n++; end
      vectors++;
      if (!tx_trigger_out) begin
        miscompares++;
        $display("FAIL reset_setup: tx_trigger=%0b required 1 within 200 cycles", tx_trigger_out);
      end
    end
    @(negedge clk_in);
    rst_n_in = 1'b0;
    #1;
    check_zero("reset_during_send");
    exp_tx_q.delete();
    exp_em_q.delete();
    for (int i = 0; i < NUM_KEYS; i++) begin model_exp[i] = '0; model_mod[i] = '0; end
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;
    repeat (8) @(negedge clk_in);
    run_frame(8'hA0, 16'h0002, 0);            // mod cleared -> EE

    vectors++;
    if (got_err != exp_err) begin
      miscompares++;
      $display("FAIL err_count: got %0d expected %0d", got_err, exp_err);
    end else $display("err pulses %0d", got_err);
    vectors++;
    if (got_ovr != exp_ovr) begin
      miscompares++;
      $display("FAIL overrun_count: got %0d expected %0d", got_ovr, exp_ovr);
    end else $display("overrun pulses %0d", got_ovr);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
